// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
// ctrl_pkg: bundle widths, control bit positions, forwarding encodings
// Rev 1.0
// ============================================================================
package ctrl_pkg;

    localparam int EX_W  = 3;
    localparam int MEM_W = 3;
    localparam int WB_W  = 2;

    // ex_ctrl = {AluSrc, AluOp[1:0]}
    localparam int ALUSRC   = 2;
    localparam int ALUOP    = 0;
    localparam int ALUOP_W  = 2;
    // mem_ctrl = {dataMemRead, dataMemWrite, Branch}
    localparam int MEMREAD  = 2;
    localparam int MEMWRITE = 1;
    localparam int BRANCH   = 0;
    // wb_ctrl = {MemtoReg, regwrite}
    localparam int MEMTOREG = 1;
    localparam int REGWRITE = 0;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_e;

endpackage
`default_nettype wire

// File: rtl/ctrl_pipeline_hazard.sv
`default_nettype none
// ============================================================================
// hazard_unit: combinational flush/stall detection and EX operand forwarding
// Option: CTRL_PIPE_FWD_EN enables forwarding (load-use stalls only). Rev 1.0
// ============================================================================
module hazard_unit
    import ctrl_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic              ex_valid,
    input  logic              ex_regwrite,
    input  logic              ex_memread,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic [REG_AW-1:0] ex_rs1,
    input  logic [REG_AW-1:0] ex_rs2,
    input  logic              ex_use_rs1,
    input  logic              ex_use_rs2,
    input  logic              mem_valid,
    input  logic              mem_regwrite,
    input  logic              mem_branch,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              wb_valid,
    input  logic              wb_regwrite,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              branch_taken,
    output logic              stall,
    output logic              flush,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b
);

    logic ex_wr;
    logic mem_wr;
    logic dep_ex;
    logic hazard;

    assign ex_wr  = ex_valid & ex_regwrite & (ex_rd != '0);
    assign mem_wr = mem_valid & mem_regwrite & (mem_rd != '0);
    assign dep_ex = id_valid & ex_wr & ((id_use_rs1 & (id_rs1 == ex_rd)) |
                                        (id_use_rs2 & (id_rs2 == ex_rd)));
    assign flush  = mem_valid & mem_branch & branch_taken;

`ifdef CTRL_PIPE_FWD_EN
    logic wb_wr;
    logic unused_mem_only;

    assign wb_wr           = wb_valid & wb_regwrite & (wb_rd != '0);
    assign hazard          = dep_ex & ex_memread;
    assign unused_mem_only = 1'b0;

    // MEM result is younger than WB, so it wins when both match
    always_comb begin
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
        if (ex_valid & ex_use_rs1 & mem_wr & (mem_rd == ex_rs1)) begin
            fwd_a = FWD_MEM;
        end else if (ex_valid & ex_use_rs1 & wb_wr & (wb_rd == ex_rs1)) begin
            fwd_a = FWD_WB;
        end
        if (ex_valid & ex_use_rs2 & mem_wr & (mem_rd == ex_rs2)) begin
            fwd_b = FWD_MEM;
        end else if (ex_valid & ex_use_rs2 & wb_wr & (wb_rd == ex_rs2)) begin
            fwd_b = FWD_WB;
        end
    end
`else
    logic dep_mem;
    logic unused_fwd_inputs;

    // WB is not checked: the register file writes through to the read port
    assign dep_mem = id_valid & mem_wr & ((id_use_rs1 & (id_rs1 == mem_rd)) |
                                          (id_use_rs2 & (id_rs2 == mem_rd)));
    assign hazard  = dep_ex | dep_mem;
    assign fwd_a   = FWD_RF;
    assign fwd_b   = FWD_RF;
    assign unused_fwd_inputs = ^{ex_memread, ex_rs1, ex_rs2, ex_use_rs1, ex_use_rs2,
                                 wb_valid, wb_regwrite, wb_rd};
`endif

    assign stall = hazard & ~flush;

endmodule
`default_nettype wire

// File: rtl/ctrl_pipeline.sv
`default_nettype none
// ============================================================================
// ctrl_pipeline: ID->EX->MEM->WB control pipeline with stall, flush, counter
// Option: CTRL_PIPE_FWD_EN enables forwarding in hazard_unit.        Rev 1.0
// ============================================================================
module ctrl_pipeline
    import ctrl_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [EX_W-1:0]   id_ex_ctrl,
    input  logic [MEM_W-1:0]  id_mem_ctrl,
    input  logic [WB_W-1:0]   id_wb_ctrl,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic              branch_taken,
    output logic              ex_valid,
    output logic [EX_W-1:0]   ex_ctrl,
    output logic [REG_AW-1:0] ex_rd,
    output logic              mem_valid,
    output logic [MEM_W-1:0]  mem_ctrl,
    output logic [REG_AW-1:0] mem_rd,
    output logic              wb_valid,
    output logic [WB_W-1:0]   wb_ctrl,
    output logic [REG_AW-1:0] wb_rd,
    output logic              stall,
    output logic              flush,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [CNT_W-1:0]  bubble_cnt
);

    typedef struct packed {
        logic              valid;
        logic [EX_W-1:0]   ex;
        logic [MEM_W-1:0]  mem;
        logic [WB_W-1:0]   wb;
        logic [REG_AW-1:0] rd;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic              use_rs1;
        logic              use_rs2;
    } ex_stage_t;

    typedef struct packed {
        logic              valid;
        logic [MEM_W-1:0]  mem;
        logic [WB_W-1:0]   wb;
        logic [REG_AW-1:0] rd;
    } mem_stage_t;

    typedef struct packed {
        logic              valid;
        logic [WB_W-1:0]   wb;
        logic [REG_AW-1:0] rd;
    } wb_stage_t;

    ex_stage_t        ex_d, ex_q;
    mem_stage_t       mem_d, mem_q;
    wb_stage_t        wb_d, wb_q;
    logic [CNT_W-1:0] bubble_cnt_d, bubble_cnt_q;

    hazard_unit #(.REG_AW(REG_AW)) u_hazard (
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_use_rs1   (id_use_rs1),
        .id_use_rs2   (id_use_rs2),
        .ex_valid     (ex_q.valid),
        .ex_regwrite  (ex_q.wb[REGWRITE]),
        .ex_memread   (ex_q.mem[MEMREAD]),
        .ex_rd        (ex_q.rd),
        .ex_rs1       (ex_q.rs1),
        .ex_rs2       (ex_q.rs2),
        .ex_use_rs1   (ex_q.use_rs1),
        .ex_use_rs2   (ex_q.use_rs2),
        .mem_valid    (mem_q.valid),
        .mem_regwrite (mem_q.wb[REGWRITE]),
        .mem_branch   (mem_q.mem[BRANCH]),
        .mem_rd       (mem_q.rd),
        .wb_valid     (wb_q.valid),
        .wb_regwrite  (wb_q.wb[REGWRITE]),
        .wb_rd        (wb_q.rd),
        .branch_taken (branch_taken),
        .stall        (stall),
        .flush        (flush),
        .fwd_a        (fwd_a),
        .fwd_b        (fwd_b)
    );

    // Bubbles are all-zero, so regwrite and dataMemWrite are never set in them
    always_comb begin
        ex_d          = '0;
        mem_d         = '0;
        wb_d          = '0;
        wb_d.valid    = mem_q.valid;
        wb_d.wb       = mem_q.wb;
        wb_d.rd       = mem_q.rd;
        mem_d.valid   = ex_q.valid;
        mem_d.mem     = ex_q.mem;
        mem_d.wb      = ex_q.wb;
        mem_d.rd      = ex_q.rd;
        if (id_valid) begin
            ex_d.valid   = 1'b1;
            ex_d.ex      = id_ex_ctrl;
            ex_d.mem     = id_mem_ctrl;
            ex_d.wb      = id_wb_ctrl;
            ex_d.rd      = id_rd;
            ex_d.rs1     = id_rs1;
            ex_d.rs2     = id_rs2;
            ex_d.use_rs1 = id_use_rs1;
            ex_d.use_rs2 = id_use_rs2;
        end
        if (flush) begin
            ex_d  = '0;
            mem_d = '0;
        end else if (stall) begin
            ex_d  = '0;
        end
    end

    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if ((stall | flush) && (bubble_cnt_q != {CNT_W{1'b1}})) begin
            bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q         <= '0;
            mem_q        <= '0;
            wb_q         <= '0;
            bubble_cnt_q <= '0;
        end else begin
            ex_q         <= ex_d;
            mem_q        <= mem_d;
            wb_q         <= wb_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign ex_valid   = ex_q.valid;
    assign ex_ctrl    = ex_q.ex;
    assign ex_rd      = ex_q.rd;
    assign mem_valid  = mem_q.valid;
    assign mem_ctrl   = mem_q.mem;
    assign mem_rd     = mem_q.rd;
    assign wb_valid   = wb_q.valid;
    assign wb_ctrl    = wb_q.wb;
    assign wb_rd      = wb_q.rd;
    assign bubble_cnt = bubble_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_pipeline.sv
`default_nettype none
// ============================================================================
// tb_ctrl_pipeline: directed scenarios plus random stimulus vs. a stage model
// Follows CTRL_PIPE_FWD_EN when defined.                              Rev 1.0
// ============================================================================
module tb_ctrl_pipeline;
    import ctrl_pkg::*;

    localparam int AW = 5;
`ifdef CTRL_PIPE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          id_valid = 1'b0;
    logic [2:0]    id_ex_ctrl = '0;
    logic [2:0]    id_mem_ctrl = '0;
    logic [1:0]    id_wb_ctrl = '0;
    logic [AW-1:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic          id_use_rs1 = 1'b0, id_use_rs2 = 1'b0, branch_taken = 1'b0;

    logic          ex_valid, mem_valid, wb_valid, stall, flush;
    logic [2:0]    ex_ctrl, mem_ctrl;
    logic [1:0]    wb_ctrl, fwd_a, fwd_b;
    logic [AW-1:0] ex_rd, mem_rd, wb_rd;
    logic [15:0]   bubble_cnt;

    logic          unused_s_ex_valid, unused_s_mem_valid, unused_s_wb_valid;
    logic          unused_s_stall, unused_s_flush;
    logic [2:0]    unused_s_ex_ctrl, unused_s_mem_ctrl;
    logic [1:0]    unused_s_wb_ctrl, unused_s_fwd_a, unused_s_fwd_b;
    logic [AW-1:0] unused_s_ex_rd, unused_s_mem_rd, unused_s_wb_rd;
    logic [3:0]    s_bubble_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ctrl_pipeline #(.REG_AW(AW), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ex_ctrl(id_ex_ctrl),
        .id_mem_ctrl(id_mem_ctrl), .id_wb_ctrl(id_wb_ctrl), .id_rs1(id_rs1),
        .id_rs2(id_rs2), .id_rd(id_rd), .id_use_rs1(id_use_rs1),
        .id_use_rs2(id_use_rs2), .branch_taken(branch_taken),
        .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_rd(ex_rd),
        .mem_valid(mem_valid), .mem_ctrl(mem_ctrl), .mem_rd(mem_rd),
        .wb_valid(wb_valid), .wb_ctrl(wb_ctrl), .wb_rd(wb_rd),
        .stall(stall), .flush(flush), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .bubble_cnt(bubble_cnt)
    );

    // Narrow counter copy so saturation is reachable in a short run
    ctrl_pipeline #(.REG_AW(AW), .CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ex_ctrl(id_ex_ctrl),
        .id_mem_ctrl(id_mem_ctrl), .id_wb_ctrl(id_wb_ctrl), .id_rs1(id_rs1),
        .id_rs2(id_rs2), .id_rd(id_rd), .id_use_rs1(id_use_rs1),
        .id_use_rs2(id_use_rs2), .branch_taken(branch_taken),
        .ex_valid(unused_s_ex_valid), .ex_ctrl(unused_s_ex_ctrl), .ex_rd(unused_s_ex_rd),
        .mem_valid(unused_s_mem_valid), .mem_ctrl(unused_s_mem_ctrl), .mem_rd(unused_s_mem_rd),
        .wb_valid(unused_s_wb_valid), .wb_ctrl(unused_s_wb_ctrl), .wb_rd(unused_s_wb_rd),
        .stall(unused_s_stall), .flush(unused_s_flush), .fwd_a(unused_s_fwd_a),
        .fwd_b(unused_s_fwd_b), .bubble_cnt(s_bubble_cnt)
    );

    // Reference model: one whole instruction record per stage
    typedef struct packed {
        logic          v;
        logic [2:0]    ex;
        logic [2:0]    mem;
        logic [1:0]    wb;
        logic [AW-1:0] rd, rs1, rs2;
        logic          u1, u2;
    } ins_t;

    ins_t st_e, st_m, st_w;
    int unsigned n_bub;

    function automatic logic writes(ins_t p);
        return p.v && p.wb[REGWRITE] && (p.rd != 0);
    endfunction

    function automatic logic reads(ins_t c, logic [AW-1:0] r);
        return c.v && ((c.u1 && c.rs1 == r) || (c.u2 && c.rs2 == r));
    endfunction

    function automatic ins_t id_ins();
        ins_t c = '0;
        if (id_valid) c = '{1'b1, id_ex_ctrl, id_mem_ctrl, id_wb_ctrl, id_rd, id_rs1, id_rs2,
                            id_use_rs1, id_use_rs2};
        return c;
    endfunction

    function automatic logic m_flush();
        return st_m.v && st_m.mem[BRANCH] && branch_taken;
    endfunction

    function automatic logic m_stall();
        ins_t c = id_ins();
        logic h;
`ifdef CTRL_PIPE_FWD_EN
        h = writes(st_e) && reads(c, st_e.rd) && st_e.mem[MEMREAD];
`else
        h = (writes(st_e) && reads(c, st_e.rd)) || (writes(st_m) && reads(c, st_m.rd));
`endif
        return h && !m_flush();
    endfunction

    function automatic logic [1:0] m_fwd(logic [AW-1:0] r, logic used);
        logic [1:0] f = 2'b00;
        if (st_e.v && used) begin
            if (writes(st_m) && st_m.rd == r)      f = 2'b10;
            else if (writes(st_w) && st_w.rd == r) f = 2'b01;
        end
        if (!FWD) f = 2'b00;
        return f;
    endfunction

    function automatic logic [15:0] sat16();
        return (n_bub > 65535) ? 16'hFFFF : 16'(n_bub);
    endfunction

    function automatic logic [3:0] sat4();
        return (n_bub > 15) ? 4'hF : 4'(n_bub);
    endfunction

    task automatic model_reset();
        st_e = '0; st_m = '0; st_w = '0; n_bub = 0;
    endtask

    task automatic tick();
        logic s, f;
        ins_t nid;
        s = m_stall(); f = m_flush(); nid = id_ins();
        @(posedge clk);
        if (rst_n) begin
            st_w = st_m;
            if (f)      begin st_e = '0; st_m = '0; end
            else if (s) begin st_m = st_e; st_e = '0; end
            else        begin st_m = st_e; st_e = nid; end
            if (s || f) n_bub++;
        end
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] exc, input logic [2:0] memc,
                         input logic [1:0] wbc, input logic [AW-1:0] rd,
                         input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                         input logic u1, input logic u2);
        id_valid = v; id_ex_ctrl = exc; id_mem_ctrl = memc; id_wb_ctrl = wbc;
        id_rd = rd; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; branch_taken = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(posedge clk); #1;
    endtask

    task automatic rand_id();
        id_valid    = ($urandom_range(0, 9) < 8);
        id_ex_ctrl  = 3'($urandom);
        id_mem_ctrl = 3'($urandom);
        id_mem_ctrl[BRANCH] = ($urandom_range(0, 3) == 0);
        id_wb_ctrl  = 2'($urandom);
        id_rd       = AW'($urandom_range(0, 3));
        id_rs1      = AW'($urandom_range(0, 3));
        id_rs2      = AW'($urandom_range(0, 3));
        id_use_rs1  = 1'($urandom);
        id_use_rs2  = 1'($urandom);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; branch_taken = 1'b1;
        drive(1, 3'b111, 3'b111, 2'b11, 5, 5, 5, 1, 1);
        repeat (2) @(posedge clk);
        #2;
        checks++; if ({ex_valid, mem_valid, wb_valid} !== 3'b000) begin failures++;
            $display("FAIL reset_valid got=%b exp=000", {ex_valid, mem_valid, wb_valid}); end
        checks++; if ({ex_ctrl, mem_ctrl, wb_ctrl, ex_rd, mem_rd, wb_rd} !== '0) begin failures++;
            $display("FAIL reset_ctrl_rd got=%h exp=0", {ex_ctrl, mem_ctrl, wb_ctrl, ex_rd, mem_rd, wb_rd}); end
        checks++; if (bubble_cnt !== 16'd0) begin failures++;
            $display("FAIL reset_cnt got=%0d exp=0", bubble_cnt); end
        checks++; if ({stall, flush, fwd_a, fwd_b} !== 6'b0) begin failures++;
            $display("FAIL reset_comb got=%b exp=000000", {stall, flush, fwd_a, fwd_b}); end
        do_reset();
    endtask

    task automatic test_back_to_back();
        do_reset();
        drive(1, 3'b010, 3'b000, 2'b01, 1, 10, 11, 1, 1);
        @(negedge clk);
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL b2b_stall0 got=%b exp=0", stall); end
        tick();
        drive(1, 3'b110, 3'b000, 2'b01, 2, 12, 13, 1, 1);
        @(negedge clk);
        checks++; if ({ex_valid, ex_ctrl, ex_rd} !== {1'b1, 3'b010, 5'd1}) begin failures++;
            $display("FAIL b2b_ex1 got=%h exp=%h", {ex_valid, ex_ctrl, ex_rd}, {1'b1, 3'b010, 5'd1}); end
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL b2b_stall1 got=%b exp=0", stall); end
        tick();
        drive(1, 3'b011, 3'b000, 2'b01, 3, 14, 15, 1, 1);
        @(negedge clk);
        checks++; if ({mem_valid, mem_ctrl, mem_rd, ex_rd} !== {1'b1, 3'b000, 5'd1, 5'd2}) begin failures++;
            $display("FAIL b2b_mem1 got=%h exp=%h", {mem_valid, mem_ctrl, mem_rd, ex_rd}, {1'b1, 3'b000, 5'd1, 5'd2}); end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checks++; if ({wb_valid, wb_ctrl, wb_rd, mem_rd, ex_rd} !== {1'b1, 2'b01, 5'd1, 5'd2, 5'd3}) begin failures++;
            $display("FAIL b2b_wb1 got=%h exp=%h", {wb_valid, wb_ctrl, wb_rd, mem_rd, ex_rd}, {1'b1, 2'b01, 5'd1, 5'd2, 5'd3}); end
        checks++; if (bubble_cnt !== 16'd0) begin failures++; $display("FAIL b2b_cnt got=%0d exp=0", bubble_cnt); end
        tick();
    endtask

    task automatic test_raw_alu();
        int nst = FWD ? 0 : 2;
        logic [1:0] ef = FWD ? 2'b10 : 2'b00;
        do_reset();
        drive(1, 3'b010, 3'b000, 2'b01, 5, 1, 2, 1, 1);
        tick();
        drive(1, 3'b010, 3'b000, 2'b01, 7, 5, 5, 1, 1);
        for (int k = 0; k <= nst; k++) begin
            @(negedge clk);
            checks++; if (stall !== (k < nst)) begin failures++;
                $display("FAIL raw_stall k=%0d got=%b exp=%b", k, stall, (k < nst)); end
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checks++; if ({ex_valid, ex_rd} !== {1'b1, 5'd7}) begin failures++;
            $display("FAIL raw_ex got=%h exp=%h", {ex_valid, ex_rd}, {1'b1, 5'd7}); end
        checks++; if ({fwd_a, fwd_b} !== {ef, ef}) begin failures++;
            $display("FAIL raw_fwd got=%b exp=%b", {fwd_a, fwd_b}, {ef, ef}); end
        checks++; if (bubble_cnt !== 16'(nst)) begin failures++;
            $display("FAIL raw_cnt got=%0d exp=%0d", bubble_cnt, nst); end
        tick();
    endtask

    task automatic test_load_use();
        int nst = FWD ? 1 : 2;
        logic [1:0] ef = FWD ? 2'b01 : 2'b00;
        do_reset();
        drive(1, 3'b000, 3'b100, 2'b11, 5, 3, 4, 1, 1);
        tick();
        drive(1, 3'b010, 3'b000, 2'b01, 6, 5, 1, 1, 1);
        for (int k = 0; k <= nst; k++) begin
            @(negedge clk);
            if (k > 0) begin
                checks++; if (ex_valid !== 1'b0) begin failures++;
                    $display("FAIL lu_bubble k=%0d got=%b exp=0", k, ex_valid); end
            end
            checks++; if (stall !== (k < nst)) begin failures++;
                $display("FAIL lu_stall k=%0d got=%b exp=%b", k, stall, (k < nst)); end
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checks++; if ({ex_valid, ex_rd} !== {1'b1, 5'd6}) begin failures++;
            $display("FAIL lu_ex got=%h exp=%h", {ex_valid, ex_rd}, {1'b1, 5'd6}); end
        checks++; if ({fwd_a, fwd_b} !== {ef, 2'b00}) begin failures++;
            $display("FAIL lu_fwd got=%b exp=%b", {fwd_a, fwd_b}, {ef, 2'b00}); end
        checks++; if (bubble_cnt !== 16'(nst)) begin failures++;
            $display("FAIL lu_cnt got=%0d exp=%0d", bubble_cnt, nst); end
        tick();
    endtask

    task automatic test_flush();
        do_reset();
        drive(1, 3'b001, 3'b001, 2'b00, 0, 1, 2, 1, 1);
        tick();
        drive(1, 3'b000, 3'b100, 2'b11, 5, 3, 4, 1, 1);
        tick();
        drive(1, 3'b010, 3'b000, 2'b01, 6, 5, 5, 1, 1);
        branch_taken = 1'b1;
        @(negedge clk);
        checks++; if ({flush, stall} !== 2'b10) begin failures++;
            $display("FAIL flush_comb got=%b exp=10", {flush, stall}); end
        tick();
        branch_taken = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checks++; if ({ex_valid, ex_ctrl, ex_rd, mem_valid, mem_ctrl, mem_rd} !== '0) begin failures++;
            $display("FAIL flush_bubbles got=%h exp=0", {ex_valid, ex_ctrl, ex_rd, mem_valid, mem_ctrl, mem_rd}); end
        checks++; if ({wb_valid, wb_ctrl, wb_rd} !== {1'b1, 2'b00, 5'd0}) begin failures++;
            $display("FAIL flush_wb got=%h exp=%h", {wb_valid, wb_ctrl, wb_rd}, {1'b1, 2'b00, 5'd0}); end
        checks++; if (bubble_cnt !== 16'd1) begin failures++;
            $display("FAIL flush_cnt got=%0d exp=1", bubble_cnt); end
        tick();
    endtask

    task automatic test_x0();
        do_reset();
        drive(1, 3'b000, 3'b100, 2'b11, 0, 3, 4, 1, 1);
        tick();
        drive(1, 3'b010, 3'b000, 2'b01, 6, 0, 0, 1, 1);
        @(negedge clk);
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL x0_stall got=%b exp=0", stall); end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checks++; if ({ex_valid, fwd_a, fwd_b} !== 5'b10000) begin failures++;
            $display("FAIL x0_fwd got=%b exp=10000", {ex_valid, fwd_a, fwd_b}); end
        checks++; if (bubble_cnt !== 16'd0) begin failures++; $display("FAIL x0_cnt got=%0d exp=0", bubble_cnt); end
        tick();
    endtask

    task automatic load_use_pair();
        int k = 0;
        logic s = 1'b1;
        drive(1, 3'b000, 3'b100, 2'b11, 5, 3, 4, 1, 1);
        tick();
        drive(1, 3'b010, 3'b000, 2'b01, 6, 5, 1, 1, 0);
        while (s && k < 4) begin
            @(negedge clk);
            s = m_stall();
            tick();
            k++;
        end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int i = 0; i < 20; i++) load_use_pair();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checks++; if (s_bubble_cnt !== 4'hF) begin failures++;
            $display("FAIL sat_cnt got=%0d exp=15", s_bubble_cnt); end
        checks++; if (bubble_cnt !== sat16()) begin failures++;
            $display("FAIL sat_wide_cnt got=%0d exp=%0d", bubble_cnt, sat16()); end
        load_use_pair();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checks++; if (s_bubble_cnt !== 4'hF) begin failures++;
            $display("FAIL sat_hold got=%0d exp=15", s_bubble_cnt); end
        tick();
    endtask

    task automatic test_random();
        logic es, ef;
        logic [1:0] ea, eb;
        do_reset();
        rand_id();
        for (int c = 0; c < 400; c++) begin
            branch_taken = ($urandom_range(0, 1) == 1);
            @(negedge clk);
            es = m_stall(); ef = m_flush();
            ea = m_fwd(st_e.rs1, st_e.u1); eb = m_fwd(st_e.rs2, st_e.u2);
            checks++; if (stall !== es) begin failures++; $display("FAIL rnd_stall c=%0d got=%b exp=%b", c, stall, es); end
            checks++; if (flush !== ef) begin failures++; $display("FAIL rnd_flush c=%0d got=%b exp=%b", c, flush, ef); end
            checks++; if ({fwd_a, fwd_b} !== {ea, eb}) begin failures++;
                $display("FAIL rnd_fwd c=%0d got=%b exp=%b", c, {fwd_a, fwd_b}, {ea, eb}); end
            checks++; if ({ex_valid, ex_ctrl, ex_rd} !== {st_e.v, st_e.ex, st_e.rd}) begin failures++;
                $display("FAIL rnd_ex c=%0d got=%h exp=%h", c, {ex_valid, ex_ctrl, ex_rd}, {st_e.v, st_e.ex, st_e.rd}); end
            checks++; if ({mem_valid, mem_ctrl, mem_rd} !== {st_m.v, st_m.mem, st_m.rd}) begin failures++;
                $display("FAIL rnd_mem c=%0d got=%h exp=%h", c, {mem_valid, mem_ctrl, mem_rd}, {st_m.v, st_m.mem, st_m.rd}); end
            checks++; if ({wb_valid, wb_ctrl, wb_rd} !== {st_w.v, st_w.wb, st_w.rd}) begin failures++;
                $display("FAIL rnd_wb c=%0d got=%h exp=%h", c, {wb_valid, wb_ctrl, wb_rd}, {st_w.v, st_w.wb, st_w.rd}); end
            checks++; if (bubble_cnt !== sat16()) begin failures++;
                $display("FAIL rnd_cnt c=%0d got=%0d exp=%0d", c, bubble_cnt, sat16()); end
            checks++; if (s_bubble_cnt !== sat4()) begin failures++;
                $display("FAIL rnd_cnt4 c=%0d got=%0d exp=%0d", c, s_bubble_cnt, sat4()); end
            tick();
            if (!es) rand_id();
        end
    endtask

    task automatic test_mid_reset();
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if ({ex_valid, mem_valid, wb_valid, bubble_cnt, s_bubble_cnt} !== '0) begin failures++;
            $display("FAIL midrst_state got=%h exp=0", {ex_valid, mem_valid, wb_valid, bubble_cnt, s_bubble_cnt}); end
        checks++; if ({stall, flush, fwd_a, fwd_b} !== 6'b0) begin failures++;
            $display("FAIL midrst_comb got=%b exp=000000", {stall, flush, fwd_a, fwd_b}); end
        @(negedge clk); #1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        branch_taken = 1'b0;
        rst_n = 1'b1;
        model_reset();
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if ({ex_valid, mem_valid, wb_valid} !== 3'b000) begin failures++;
            $display("FAIL midrst_empty got=%b exp=000", {ex_valid, mem_valid, wb_valid}); end
        drive(1, 3'b010, 3'b000, 2'b01, 9, 1, 2, 1, 1);
        tick();
        @(negedge clk);
        checks++; if ({ex_valid, ex_rd, mem_valid} !== {1'b1, 5'd9, 1'b0}) begin failures++;
            $display("FAIL midrst_restart got=%h exp=%h", {ex_valid, ex_rd, mem_valid}, {1'b1, 5'd9, 1'b0}); end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_back_to_back();
        test_raw_alu();
        test_load_use();
        test_flush();
        test_x0();
        test_saturate();
        test_random();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ctrl_pipeline.md
CTRL_PIPELINE -- requirements
Module: ctrl_pipeline

Interface
REQ-001 Parameter: REG_AW, 5, register-address width.
REQ-002 Parameter: CNT_W, 16, bubble-counter width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 id_valid  in  1  decoded instruction present in ID.
REQ-006 id_ex_ctrl  in  3  {AluSrc, AluOp[1:0]}.
REQ-007 id_mem_ctrl  in  3  {dataMemRead, dataMemWrite, Branch}.
REQ-008 id_wb_ctrl  in  2  {MemtoReg, regwrite}.
REQ-009 id_rs1, id_rs2, id_rd  in  REG_AW each  ID operand/destination addresses.
REQ-010 id_use_rs1, id_use_rs2  in  1 each  operand actually read.
REQ-011 branch_taken  in  1  branch outcome for the instruction in MEM.
REQ-012 ex_valid, ex_ctrl[2:0], ex_rd  out  EX-stage bundle; ex_ctrl drives ALU.
REQ-013 mem_valid, mem_ctrl[2:0], mem_rd  out  MEM-stage bundle.
REQ-014 wb_valid, wb_ctrl[1:0], wb_rd  out  WB-stage bundle.
REQ-015 stall  out  1  hold PC and IF/ID this cycle.
REQ-016 flush  out  1  redirect fetch; clear IF/ID this cycle.
REQ-017 fwd_a, fwd_b  out  2 each  EX operand source: 00 regfile, 10 MEM result, 01 WB result.
REQ-018 bubble_cnt  out  CNT_W  count of inserted bubbles.

Function
REQ-019 The block SHALL register ID control into EX, EX into MEM, and MEM into WB each cycle, one stage per clock, with rd and rs1/rs2 carried alongside.
REQ-020 The EX stage SHALL hold all three bundles, MEM SHALL hold mem+wb bundles, and WB SHALL hold only the wb bundle.
REQ-021 flush SHALL be combinational = mem_valid & mem_ctrl.Branch & branch_taken.
REQ-022 On flush, the next EX and MEM SHALL be bubbles (valid=0, all ctrl=0, rd=0), and WB SHALL receive the branch from MEM.
REQ-023 A hazard SHALL require id_valid, a used operand equal to a producer rd, producer valid & regwrite, and producer rd != 0.
REQ-024 On a hazard without flush, stall=1, the next EX SHALL be a bubble, and MEM/WB SHALL advance normally.
REQ-025 flush SHALL take priority over stall; stall SHALL be 0 whenever flush=1.
REQ-026 A WB-to-ID dependency SHALL NOT stall, because the register file is write-through.
REQ-027 bubble_cnt SHALL increment by 1 per cycle with stall or flush, and SHALL saturate at all-ones.
REQ-028 Bubbles SHALL carry regwrite=0 and dataMemWrite=0 in every stage.

Reset
REQ-029 While rst_n=0, all valid bits, ctrl fields, rd fields and bubble_cnt SHALL be 0 immediately, regardless of clk.
REQ-030 stall, flush, fwd_a and fwd_b SHALL read 0 during reset.
REQ-031 Deassertion mid-program SHALL restart with empty EX/MEM/WB.

Configuration
REQ-032 Macro CTRL_PIPE_FWD_EN: when defined, forwarding SHALL be active.
REQ-033 With CTRL_PIPE_FWD_EN, fwd_a/fwd_b SHALL select per EX operand, with MEM (10) priority over WB (01).
REQ-034 With CTRL_PIPE_FWD_EN, a hazard SHALL stall only if the EX producer has dataMemRead=1 (load-use, exactly one bubble).
REQ-035 Without CTRL_PIPE_FWD_EN, fwd_a/fwd_b SHALL be tied to 00.
REQ-036 Without CTRL_PIPE_FWD_EN, a hazard against an EX or MEM producer SHALL stall until the producer leaves MEM.

Structure
REQ-037 Package ctrl_pkg SHALL hold the bundle widths, bit-index constants (ALUSRC, ALUOP, MEMREAD, MEMWRITE, BRANCH, MEMTOREG, REGWRITE) and fwd encodings.
REQ-038 Hazard/forward comparison SHALL be a combinational sub-module hazard_unit; pipeline registers and the counter SHALL stay in ctrl_pipeline.

Verification
REQ-039 Cover: back-to-back ALU ops, no hazards -> bundles appear at EX/MEM/WB on cycles 1/2/3, stall=0, bubble_cnt=0.
REQ-040 Cover: load x5 then add x6,x5,x1 with FWD_EN -> one stall cycle, EX bubble, then fwd_a=10 is not used and fwd_a=01 next, bubble_cnt=1.
REQ-041 Cover: add x5 then sub x7,x5,x5 without FWD_EN -> two stall cycles, bubble_cnt=2; with FWD_EN -> no stall, fwd_a=fwd_b=10.
REQ-042 Cover: taken branch reaching MEM while a hazard is pending in ID -> flush=1, stall=0, EX/MEM next cycle invalid, branch in WB.
REQ-043 Cover: hazard on rd=x0 with regwrite=1 -> no stall, fwd=00.
REQ-044 Cover: rst_n pulled low mid-stream between clk edges -> all valids 0 and bubble_cnt 0 before the next edge; bubble_cnt forced to 0xFFFF holds under further stalls.
